// File: rtl/avl_if.sv
// Avalon-MM bus between the SoC avl master and a memory-mapped responder.
interface avl_if;
  logic [31:0] avs_address;
  logic [3:0]  avs_byteenable;
  logic        avs_lock;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [2:0]  avs_burstcount;
  logic [31:0] avs_readdata;
  logic [1:0]  avs_response;
  logic        avs_waitrequest;
  logic        avs_readdatavalid;
  logic        avs_writeresponsevalid;

  modport master (
    output avs_address, avs_byteenable, avs_lock, avs_read, avs_write,
           avs_writedata, avs_burstcount,
    input  avs_readdata, avs_response, avs_waitrequest, avs_readdatavalid,
           avs_writeresponsevalid
  );

  modport slave (
    input  avs_address, avs_byteenable, avs_lock, avs_read, avs_write,
           avs_writedata, avs_burstcount,
    output avs_readdata, avs_response, avs_waitrequest, avs_readdatavalid,
           avs_writeresponsevalid
  );
endinterface

// File: rtl/avl_mem_responder.sv
// Avalon-MM responder over a word-addressed on-chip RAM with programmable
// wait states, read latency, incrementing bursts and decode-error responses.
module avl_mem_responder #(
  parameter int ADDR_BITS    = 14,
  parameter int WAIT_CYCLES  = 1,
  parameter int READ_LATENCY = 2
) (
  input  logic clock,
  input  logic reset,
  avl_if.slave avs
);
  localparam int L       = READ_LATENCY;
  localparam int DEPTH_W = 1 << ADDR_BITS;
  localparam logic [32:0] DEPTH = 33'd1 << ADDR_BITS;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STALL  = 3'd1;
  localparam logic [2:0] S_ACCEPT = 3'd2;
  localparam logic [2:0] S_RD     = 3'd3;
  localparam logic [2:0] S_WR     = 3'd4;
  localparam logic [2:0] S_WRESP  = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [29:0] base_q, base_d;
  logic [2:0]  burst_q, burst_d;
  logic [2:0]  beat_q, beat_d;
  logic        werr_q, werr_d;

  logic [31:0] mem [DEPTH_W];
  logic [L:1]        vld_pipe;
  logic [L:1][31:0]  dat_pipe;
  logic [L:1]        err_pipe;

  logic        acc_st, cmd, accept, issue, mem_we, in_range, pipe_busy;
  logic [29:0] cur_base;
  logic [2:0]  cur_k, bc_eff;
  logic [32:0] beat_addr;
  logic [ADDR_BITS-1:0] idx;
  logic        unused_ok;

  assign unused_ok = ^{avs.avs_lock, avs.avs_address[1:0]};

  assign acc_st = (state_q == S_ACCEPT) || (state_q == S_IDLE && WAIT_CYCLES == 0);
  assign cmd    = avs.avs_read | avs.avs_write;
  assign accept = acc_st & cmd;
  assign bc_eff = (avs.avs_burstcount == 3'd0) ? 3'd1 : avs.avs_burstcount;

  // On the accept cycle the bus address is live; later beats use the sampled base.
  assign cur_base  = accept ? avs.avs_address[31:2] : base_q;
  assign cur_k     = accept ? 3'd0 : beat_q;
  assign beat_addr = {3'b0, cur_base} + {30'b0, cur_k};
  assign in_range  = beat_addr < DEPTH;
  assign idx       = beat_addr[ADDR_BITS-1:0];

  assign issue  = reset & ((accept & avs.avs_read) | (state_q == S_RD && beat_q != burst_q));
  assign mem_we = reset & in_range & avs.avs_write &
                  ((accept & ~avs.avs_read) | (state_q == S_WR));

  always_comb begin
    pipe_busy = 1'b0;
    for (int s = 1; s < L; s++) pipe_busy = pipe_busy | vld_pipe[s];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    werr_d  = werr_q;
    case (state_q)
      // The IDLE cycle itself is the first stall cycle.
      S_IDLE: if (WAIT_CYCLES != 0 && cmd) begin
        cnt_d   = 3'd1;
        state_d = (WAIT_CYCLES == 1) ? S_ACCEPT : S_STALL;
      end
      S_STALL: begin
        cnt_d = cnt_q + 3'd1;
        if ((4'(cnt_q) + 4'd1) == 4'(WAIT_CYCLES)) state_d = S_ACCEPT;
      end
      S_ACCEPT: if (!cmd) state_d = S_IDLE;
      S_RD: begin
        if (beat_q != burst_q) beat_d = beat_q + 3'd1;
        else if (!pipe_busy) state_d = S_IDLE;
      end
      S_WR: if (avs.avs_write) begin
        beat_d = beat_q + 3'd1;
        werr_d = werr_q | ~in_range;
        if (beat_q + 3'd1 == burst_q) state_d = S_WRESP;
      end
      S_WRESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      base_d  = avs.avs_address[31:2];
      burst_d = bc_eff;
      beat_d  = 3'd1;
      if (avs.avs_read) state_d = S_RD;
      else begin
        werr_d  = ~in_range;
        state_d = (bc_eff == 3'd1) ? S_WRESP : S_WR;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      werr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      werr_q  <= werr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (avs.avs_byteenable[i]) mem[idx][8*i +: 8] <= avs.avs_writedata[8*i +: 8];
  end

  // Stage 1 is the RAM read register; data stages load only on valid so
  // readdata holds between beats.
  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
      err_pipe <= '0;
    end else begin
      vld_pipe[1] <= issue;
      if (issue) begin
        dat_pipe[1] <= mem[idx];
        err_pipe[1] <= ~in_range;
      end
      for (int s = 2; s <= L; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) begin
          dat_pipe[s] <= dat_pipe[s-1];
          err_pipe[s] <= err_pipe[s-1];
        end
      end
    end
  end

  assign avs.avs_waitrequest        = ~reset | ~(acc_st | (state_q == S_WR));
  assign avs.avs_readdatavalid      = vld_pipe[L];
  assign avs.avs_readdata           = err_pipe[L] ? 32'd0 : dat_pipe[L];
  assign avs.avs_writeresponsevalid = (state_q == S_WRESP);
  assign avs.avs_response = ((vld_pipe[L] & err_pipe[L]) | ((state_q == S_WRESP) & werr_q))
                            ? 2'b11 : 2'b00;
endmodule

// File: tb/tb_avl_mem_responder.sv
// Scoreboard bench: a full-size responder plus a 16-word one for decode errors.
module tb_avl_mem_responder;
  logic clock, reset, sel;
  logic [31:0] a, wd;
  logic [3:0]  be;
  logic        rd, wr;
  logic [2:0]  bc;
  int cyc = 0;
  int n_chk = 0, n_fail = 0;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    logic [1:0]  resp;
    int          cyc;
  } exp_t;
  exp_t q[$];

  avl_if if_big();
  avl_if if_small();

  assign if_big.avs_address      = a;
  assign if_big.avs_byteenable   = be;
  assign if_big.avs_lock         = 1'b0;
  assign if_big.avs_read         = rd & ~sel;
  assign if_big.avs_write        = wr & ~sel;
  assign if_big.avs_writedata    = wd;
  assign if_big.avs_burstcount   = bc;
  assign if_small.avs_address    = a;
  assign if_small.avs_byteenable = be;
  assign if_small.avs_lock       = 1'b0;
  assign if_small.avs_read       = rd & sel;
  assign if_small.avs_write      = wr & sel;
  assign if_small.avs_writedata  = wd;
  assign if_small.avs_burstcount = bc;

  logic        wait_m, rdv_m, wrv_m;
  logic [31:0] rdata_m;
  logic [1:0]  resp_m;
  assign wait_m  = sel ? if_small.avs_waitrequest        : if_big.avs_waitrequest;
  assign rdv_m   = sel ? if_small.avs_readdatavalid      : if_big.avs_readdatavalid;
  assign wrv_m   = sel ? if_small.avs_writeresponsevalid : if_big.avs_writeresponsevalid;
  assign rdata_m = sel ? if_small.avs_readdata           : if_big.avs_readdata;
  assign resp_m  = sel ? if_small.avs_response           : if_big.avs_response;

  avl_mem_responder #(.ADDR_BITS(14), .WAIT_CYCLES(1), .READ_LATENCY(2)) u_big (
    .clock(clock), .reset(reset), .avs(if_big));
  avl_mem_responder #(.ADDR_BITS(4), .WAIT_CYCLES(1), .READ_LATENCY(2)) u_small (
    .clock(clock), .reset(reset), .avs(if_small));

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every valid beat must match the head of the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (rdv_m === 1'b1 || wrv_m === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: rdv=%0b wrv=%0b at cycle %0d, expected none", rdv_m, wrv_m, cyc);
      end else begin
        e = q.pop_front();
        check("valid_kind", 32'({rdv_m, wrv_m}), e.is_rd ? 32'd2 : 32'd1);
        if (e.is_rd) check("readdata", rdata_m, e.data);
        check("response", 32'(resp_m), 32'(e.resp));
        check("valid_cycle", cyc, e.cyc);
      end
    end else if (reset === 1'b1) begin
      check("idle_response", 32'(resp_m), 32'd0);
    end
  end

  task automatic drain(input bit chk_wait);
    bit whi = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) begin
      @(negedge clock);
      if (wait_m !== 1'b1) whi = 1'b0;
    end
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", q.size());
      q.delete();
    end
    if (chk_wait) check("wait_high_rd", 32'(whi), 32'd1);
  endtask

  task automatic start_cmd(input bit r, input bit w, input logic [31:0] addr,
                           input logic [3:0] b, input logic [31:0] d,
                           input logic [2:0] n, output int acc);
    int rise;
    @(posedge clock);
    #1;
    a = addr; rd = r; wr = w; be = b; wd = d; bc = n;
    rise = cyc;
    acc = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (wait_m === 1'b0) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: no accept within 20 cycles, expected 1");
      rd = 1'b0;
      wr = 1'b0;
    end else begin
      check("accept_wait", acc - rise, 32'd1);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [3:0] b,
                          input logic [31:0] d0, d1, d2, d3,
                          input int n, input int gap_at, input logic [1:0] eresp);
    logic [31:0] d [4];
    int acc, last;
    d = '{d0, d1, d2, d3};
    start_cmd(1'b0, 1'b1, addr, b, d[0], 3'(n), acc);
    if (acc < 0) return;
    last = acc;
    @(posedge clock);
    #1;
    for (int k = 1; k < n; k++) begin
      if (k == gap_at) begin
        wr = 1'b0;
        repeat (2) begin
          @(posedge clock);
          #1;
        end
      end
      wr = 1'b1;
      wd = d[k];
      @(negedge clock);
      check("wr_beat_wait", 32'(wait_m), 32'd0);
      last = cyc;
      @(posedge clock);
      #1;
    end
    wr = 1'b0;
    q.push_back('{1'b0, 32'd0, eresp, last + 1});
    drain(1'b0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int n,
                         input logic [31:0] d0, d1, d2, d3, input logic [3:0] emask);
    logic [31:0] d [4];
    int acc;
    d = '{d0, d1, d2, d3};
    start_cmd(1'b1, 1'b0, addr, 4'hF, 32'd0, 3'(n), acc);
    if (acc < 0) return;
    for (int k = 0; k < n; k++)
      q.push_back('{1'b1, d[k], emask[k] ? 2'b11 : 2'b00, acc + 2 + k});
    @(posedge clock);
    #1;
    rd = 1'b0;
    drain(1'b1);
  endtask

  initial begin
    int acc;
    reset = 1'b0; sel = 1'b0; rd = 1'b0; wr = 1'b0;
    a = '0; wd = '0; be = '0; bc = 3'd1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_wait", 32'(wait_m), 32'd1);
    check("rst_rdv", 32'(rdv_m), 32'd0);
    check("rst_wrv", 32'(wrv_m), 32'd0);
    check("rst_rdata", rdata_m, 32'd0);
    check("rst_resp", 32'(resp_m), 32'd0);
    reset = 1'b1;

    // single write then read, and readdata holds afterwards
    do_write(32'h10, 4'hF, 32'hDEADBEEF, 0, 0, 0, 1, 0, 2'b00);
    do_read(32'h10, 1, 32'hDEADBEEF, 0, 0, 0, 4'b0000);
    repeat (3) @(negedge clock);
    check("readdata_hold", rdata_m, 32'hDEADBEEF);

    // byte enables
    do_write(32'h20, 4'hF, 32'h11223344, 0, 0, 0, 1, 0, 2'b00);
    do_write(32'h20, 4'b0101, 32'hAABBCCDD, 0, 0, 0, 1, 0, 2'b00);
    do_read(32'h20, 1, 32'h11BB33DD, 0, 0, 0, 4'b0000);

    // preload by write burst, then read burst of 4
    do_write(32'h40, 4'hF, 32'd1, 32'd2, 32'd3, 32'd4, 4, 0, 2'b00);
    do_read(32'h40, 4, 32'd1, 32'd2, 32'd3, 32'd4, 4'b0000);

    // write burst with a two-cycle gap after the first beat
    do_write(32'h80, 4'hF, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 0, 3, 1, 2'b00);
    do_read(32'h80, 3, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 0, 4'b0000);

    // reset after the first beat of a 4-beat read
    start_cmd(1'b1, 1'b0, 32'h40, 4'hF, 32'd0, 3'd4, acc);
    q.push_back('{1'b1, 32'd1, 2'b00, acc + 2});
    @(posedge clock);
    #1;
    rd = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_mid_wait", 32'(wait_m), 32'd1);
    check("rst_mid_rdv", 32'(rdv_m), 32'd0);
    reset = 1'b1;
    repeat (8) @(negedge clock);
    check("rst_mid_pending", q.size(), 32'd0);
    q.delete();
    do_read(32'h40, 4, 32'd1, 32'd2, 32'd3, 32'd4, 4'b0000);

    // decode errors on the 16-word instance
    sel = 1'b1;
    do_write(32'h00, 4'hF, 32'h01234567, 0, 0, 0, 1, 0, 2'b00);
    do_write(32'h3C, 4'hF, 32'hCAFEF00D, 0, 0, 0, 1, 0, 2'b00);
    do_read(32'h3C, 2, 32'hCAFEF00D, 32'd0, 0, 0, 4'b0010);
    do_write(32'h40, 4'hF, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 2'b11);
    do_read(32'h00, 1, 32'h01234567, 0, 0, 0, 4'b0000);
    do_read(32'h3C, 1, 32'hCAFEF00D, 0, 0, 0, 4'b0000);

    repeat (4) @(negedge clock);
    check("final_queue", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
